// File: rtl/axi4_burst_memory_slave.sv
// AXI4 burst memory slave: FIXED/INCR/WRAP bursts, IDs, byte strobes.
// Independent read and write FSMs share a single memory array.
// Build option: define AXI_MEM_WRAP_EN to build the WRAP address logic.
// Without it, every WRAP burst is completed as illegal: SLVERR on all beats, no writes.
module axi4_burst_memory_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_WORDS  = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ID_WIDTH-1:0]     S_AXI_awid,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_awaddr,
  input  logic [7:0]              S_AXI_awlen,
  input  logic [2:0]              S_AXI_awsize,
  input  logic [1:0]              S_AXI_awburst,
  input  logic                    S_AXI_awvalid,
  output logic                    S_AXI_awready,
  input  logic [DATA_WIDTH-1:0]   S_AXI_wdata,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_wstrb,
  input  logic                    S_AXI_wlast,
  input  logic                    S_AXI_wvalid,
  output logic                    S_AXI_wready,
  output logic [ID_WIDTH-1:0]     S_AXI_bid,
  output logic [1:0]              S_AXI_bresp,
  output logic                    S_AXI_bvalid,
  input  logic                    S_AXI_bready,
  input  logic [ID_WIDTH-1:0]     S_AXI_arid,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_araddr,
  input  logic [7:0]              S_AXI_arlen,
  input  logic [2:0]              S_AXI_arsize,
  input  logic [1:0]              S_AXI_arburst,
  input  logic                    S_AXI_arvalid,
  output logic                    S_AXI_arready,
  output logic [ID_WIDTH-1:0]     S_AXI_rid,
  output logic [DATA_WIDTH-1:0]   S_AXI_rdata,
  output logic [1:0]              S_AXI_rresp,
  output logic                    S_AXI_rlast,
  output logic                    S_AXI_rvalid,
  input  logic                    S_AXI_rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int TOP    = IDX_W + LSB;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
`ifdef AXI_MEM_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  function automatic logic burst_illegal(input logic [7:0] len, input logic [2:0] size,
                                         input logic [1:0] burst);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return ({29'd0, size} > 32'(LSB)) || (burst == 2'b11) ||
           ((burst == BURST_WRAP) && (!wrap_len_ok || !WRAP_EN));
  endfunction

  // Write path state
  wstate_e               wstate_q, wstate_d;
  logic [ID_WIDTH-1:0]   awid_q, awid_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]            wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [2:0]            wsize_q, wsize_d;
  logic [1:0]            wburst_q, wburst_d;
  logic                  werr_q, werr_d, willegal_q, willegal_d;
  logic                  mem_we, w_oor, w_last;
  logic [ADDR_WIDTH-1:0] w_step, w_next;
  // Read path state
  rstate_e               rstate_q, rstate_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [7:0]            rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [2:0]            rsize_q, rsize_d;
  logic [1:0]            rburst_q, rburst_d, rresp_q, rresp_d;
  logic                  rillegal_q, rillegal_d, r_ill, r_ok;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] r_step, r_next, r_look;
`ifdef AXI_MEM_WRAP_EN
  logic [ADDR_WIDTH-1:0] w_wmask, r_wmask;
`endif

  assign S_AXI_awready = (wstate_q == W_IDLE);
  assign S_AXI_wready  = (wstate_q == W_DATA);
  assign S_AXI_bvalid  = (wstate_q == W_RESP);
  assign S_AXI_bid     = awid_q;
  assign S_AXI_bresp   = werr_q ? RESP_SLVERR : RESP_OKAY;
  assign S_AXI_arready = (rstate_q == R_IDLE);
  assign S_AXI_rvalid  = (rstate_q == R_DATA);
  assign S_AXI_rid     = rid_q;
  assign S_AXI_rdata   = rdata_q;
  assign S_AXI_rresp   = rresp_q;
  assign S_AXI_rlast   = (rstate_q == R_DATA) && (rcnt_q == rlen_q);

  // Write FSM: next state, beat address advance, error accumulation, memory write enable
  always_comb begin
    wstate_d = wstate_q; awid_d = awid_q; waddr_d = waddr_q; wlen_d = wlen_q;
    wsize_d = wsize_q; wburst_d = wburst_q; wcnt_d = wcnt_q;
    werr_d = werr_q; willegal_d = willegal_q; mem_we = 1'b0;
    w_last = (wcnt_q == wlen_q);
    w_oor  = (waddr_q >> TOP) != '0;
    w_step = ADDR_WIDTH'(1) << wsize_q;
    w_next = waddr_q;
    if (wburst_q == BURST_INCR) w_next = waddr_q + w_step;
`ifdef AXI_MEM_WRAP_EN
    w_wmask = ((ADDR_WIDTH'(wlen_q) + ADDR_WIDTH'(1)) << wsize_q) - ADDR_WIDTH'(1);
    if (wburst_q == BURST_WRAP) w_next = (waddr_q & ~w_wmask) | ((waddr_q + w_step) & w_wmask);
`endif
    case (wstate_q)
      W_IDLE: if (S_AXI_awvalid) begin
        awid_d = S_AXI_awid; waddr_d = S_AXI_awaddr; wlen_d = S_AXI_awlen;
        wsize_d = S_AXI_awsize; wburst_d = S_AXI_awburst; wcnt_d = '0; werr_d = 1'b0;
        willegal_d = burst_illegal(S_AXI_awlen, S_AXI_awsize, S_AXI_awburst);
        wstate_d = W_DATA;
      end
      W_DATA: if (S_AXI_wvalid) begin
        if (willegal_q || w_oor || (S_AXI_wlast != w_last)) werr_d = 1'b1;
        mem_we  = !willegal_q && !w_oor;
        waddr_d = w_next;
        wcnt_d  = wcnt_q + 8'd1;
        if (w_last) wstate_d = W_RESP;
      end
      W_RESP: if (S_AXI_bready) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  // Write path registers
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wstate_q <= W_IDLE; awid_q <= '0; waddr_q <= '0; wlen_q <= '0; wsize_q <= '0;
      wburst_q <= '0; wcnt_q <= '0; werr_q <= 1'b0; willegal_q <= 1'b0;
    end else begin
      wstate_q <= wstate_d; awid_q <= awid_d; waddr_q <= waddr_d; wlen_q <= wlen_d;
      wsize_q <= wsize_d; wburst_q <= wburst_d; wcnt_q <= wcnt_d; werr_q <= werr_d;
      willegal_q <= willegal_d;
    end
  end

  // Byte-strobed memory write; contents survive reset
  always_ff @(posedge ACLK) begin
    if (mem_we && ARESETN)
      for (int unsigned b = 0; b < STRB_W; b++)
        if (S_AXI_wstrb[b]) mem[waddr_q[LSB +: IDX_W]][b*8 +: 8] <= S_AXI_wdata[b*8 +: 8];
  end

  // Read FSM: the beat being loaded is the AR address when idle, else the next burst address,
  // so rdata is registered one cycle ahead and a beat is presented every accepted cycle
  always_comb begin
    rstate_d = rstate_q; rid_d = rid_q; raddr_d = raddr_q; rlen_d = rlen_q;
    rsize_d = rsize_q; rburst_d = rburst_q; rcnt_d = rcnt_q; rillegal_d = rillegal_q;
    rdata_d = rdata_q; rresp_d = rresp_q;
    r_step = ADDR_WIDTH'(1) << rsize_q;
    r_next = raddr_q;
    if (rburst_q == BURST_INCR) r_next = raddr_q + r_step;
`ifdef AXI_MEM_WRAP_EN
    r_wmask = ((ADDR_WIDTH'(rlen_q) + ADDR_WIDTH'(1)) << rsize_q) - ADDR_WIDTH'(1);
    if (rburst_q == BURST_WRAP) r_next = (raddr_q & ~r_wmask) | ((raddr_q + r_step) & r_wmask);
`endif
    r_look = (rstate_q == R_IDLE) ? S_AXI_araddr : r_next;
    r_ill  = (rstate_q == R_IDLE) ? burst_illegal(S_AXI_arlen, S_AXI_arsize, S_AXI_arburst)
                                  : rillegal_q;
    r_ok   = !r_ill && ((r_look >> TOP) == '0);
    case (rstate_q)
      R_IDLE: if (S_AXI_arvalid) begin
        rid_d = S_AXI_arid; raddr_d = S_AXI_araddr; rlen_d = S_AXI_arlen;
        rsize_d = S_AXI_arsize; rburst_d = S_AXI_arburst; rcnt_d = '0; rillegal_d = r_ill;
        rdata_d = r_ok ? mem[r_look[LSB +: IDX_W]] : '0;
        rresp_d = r_ok ? RESP_OKAY : RESP_SLVERR;
        rstate_d = R_DATA;
      end
      R_DATA: if (S_AXI_rready) begin
        if (rcnt_q == rlen_q) begin
          rstate_d = R_IDLE;
        end else begin
          raddr_d = r_next;
          rcnt_d  = rcnt_q + 8'd1;
          rdata_d = r_ok ? mem[r_look[LSB +: IDX_W]] : '0;
          rresp_d = r_ok ? RESP_OKAY : RESP_SLVERR;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Read path registers
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rstate_q <= R_IDLE; rid_q <= '0; raddr_q <= '0; rlen_q <= '0; rsize_q <= '0;
      rburst_q <= '0; rcnt_q <= '0; rillegal_q <= 1'b0; rdata_q <= '0; rresp_q <= '0;
    end else begin
      rstate_q <= rstate_d; rid_q <= rid_d; raddr_q <= raddr_d; rlen_q <= rlen_d;
      rsize_q <= rsize_d; rburst_q <= rburst_d; rcnt_q <= rcnt_d; rillegal_q <= rillegal_d;
      rdata_q <= rdata_d; rresp_q <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axi4_burst_memory_slave.sv
// Directed bench for axi4_burst_memory_slave with a reference byte-strobed memory model
// and per-channel scoreboards of expected B and R beats.
module tb_axi4_burst_memory_slave;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [3:0]  wstrb;

  axi4_burst_memory_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_WORDS(1024)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_awid(awid), .S_AXI_awaddr(awaddr), .S_AXI_awlen(awlen), .S_AXI_awsize(awsize),
    .S_AXI_awburst(awburst), .S_AXI_awvalid(awvalid), .S_AXI_awready(awready),
    .S_AXI_wdata(wdata), .S_AXI_wstrb(wstrb), .S_AXI_wlast(wlast), .S_AXI_wvalid(wvalid),
    .S_AXI_wready(wready), .S_AXI_bid(bid), .S_AXI_bresp(bresp), .S_AXI_bvalid(bvalid),
    .S_AXI_bready(bready), .S_AXI_arid(arid), .S_AXI_araddr(araddr), .S_AXI_arlen(arlen),
    .S_AXI_arsize(arsize), .S_AXI_arburst(arburst), .S_AXI_arvalid(arvalid),
    .S_AXI_arready(arready), .S_AXI_rid(rid), .S_AXI_rdata(rdata), .S_AXI_rresp(rresp),
    .S_AXI_rlast(rlast), .S_AXI_rvalid(rvalid), .S_AXI_rready(rready)
  );

  always #5 ACLK = ~ACLK;

`ifdef AXI_MEM_WRAP_EN
  localparam bit WRAP_ON = 1'b1;
`else
  localparam bit WRAP_ON = 1'b0;
`endif

  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rbeat_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } bresp_t;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] model [1024];
  rbeat_t      rq [$];
  bresp_t      bq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    total++;
    bad++;
    $error("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  function automatic logic tb_illegal(input logic [7:0] len, input logic [2:0] size,
                                      input logic [1:0] burst);
    return (size > 3'd2) || (burst == 2'b11) ||
           (burst == 2'b10 && (!WRAP_ON || !(len inside {8'd1, 8'd3, 8'd7, 8'd15})));
  endfunction

  // Address of beat i, computed directly from the start address rather than incrementally
  function automatic logic [31:0] beat_addr(input logic [31:0] addr, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst,
                                            input int i);
    logic [31:0] bytes, span, base;
    bytes = 32'd1 << size;
    span  = (32'(len) + 32'd1) * bytes;
    base  = addr - (addr % span);
    case (burst)
      2'b01:   return addr + 32'(i) * bytes;
      2'b10:   return base + ((addr - base) + 32'(i) * bytes) % span;
      default: return addr;
    endcase
  endfunction

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [31:0] d0, input logic [3:0] strb,
                           input bit bad_wlast, input int abort_at);
    logic ill, err;
    logic [31:0] a;
    logic [9:0] idx;
    bresp_t b;
    int n;
    ill = tb_illegal(len, size, burst);
    err = ill | bad_wlast;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 200) begin @(negedge ACLK); n++; end
    if (n >= 200) timeout_fail("aw_handshake");
    @(negedge ACLK);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (abort_at == i) begin
        wvalid = 1'b0;
        ARESETN = 1'b0;
        @(negedge ACLK);
        ARESETN = 1'b1;
        return;
      end
      a = beat_addr(addr, len, size, burst, i);
      wdata = d0 + 32'(i); wstrb = strb; wlast = ((i == int'(len)) != bad_wlast); wvalid = 1'b1;
      if (!ill && a < 32'd4096) begin
        idx = a[11:2];
        for (int k = 0; k < 4; k++) if (strb[k]) model[idx][k*8 +: 8] = wdata[k*8 +: 8];
      end else begin
        err = 1'b1;
      end
      n = 0;
      while (!wready && n < 200) begin @(negedge ACLK); n++; end
      if (n >= 200) timeout_fail("w_handshake");
      @(negedge ACLK);
    end
    wvalid = 1'b0; wlast = 1'b0;
    b.id = id; b.resp = err ? 2'b10 : 2'b00;
    bq.push_back(b);
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 200) begin @(negedge ACLK); n++; end
    if (n >= 200) begin
      timeout_fail("b_handshake");
    end else begin
      b = bq.pop_front();
      chk("bid", 32'(bid), 32'(b.id));
      chk("bresp", 32'(bresp), 32'(b.resp));
    end
    @(negedge ACLK);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit stall);
    logic ill, ok, stalled;
    logic [31:0] a, held_data;
    logic [9:0] idx;
    logic [1:0] held_resp;
    logic held_last;
    rbeat_t e;
    int n, got, k;
    ill = tb_illegal(len, size, burst);
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, len, size, burst, i);
      ok = !ill && a < 32'd4096;
      idx = a[11:2];
      e.id = id; e.data = ok ? model[idx] : 32'd0; e.resp = ok ? 2'b00 : 2'b10;
      e.last = (i == int'(len));
      rq.push_back(e);
    end
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 200) begin @(negedge ACLK); n++; end
    if (n >= 200) timeout_fail("ar_handshake");
    @(negedge ACLK);
    arvalid = 1'b0;
    got = 0; k = 0; stalled = 1'b0;
    held_data = '0; held_resp = '0; held_last = 1'b0;
    while (got <= int'(len) && k < 2000) begin
      rready = stall ? (k % 3 == 0) : 1'b1;
      if (stalled) begin
        chk("r_hold_valid", 32'(rvalid), 32'd1);
        chk("r_hold_data", rdata, held_data);
        chk("r_hold_resp_last", {29'd0, rresp, rlast}, {29'd0, held_resp, held_last});
      end
      stalled = 1'b0;
      if (rvalid) begin
        if (rready) begin
          e = rq.pop_front();
          chk("rdata", rdata, e.data);
          chk("rresp", 32'(rresp), 32'(e.resp));
          chk("rlast", 32'(rlast), 32'(e.last));
          chk("rid", 32'(rid), 32'(e.id));
          got++;
        end else begin
          stalled = 1'b1; held_data = rdata; held_resp = rresp; held_last = rlast;
        end
      end
      @(negedge ACLK);
      k++;
    end
    rready = 1'b0;
    if (got <= int'(len)) timeout_fail("r_beats");
    chk("rvalid_after_burst", 32'(rvalid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ARESETN = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < 1024; i++) model[i] = '0;
    repeat (3) @(negedge ACLK);
    chk("rst_awready", 32'(awready), 32'd1);
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid_rlast", {30'd0, rvalid, rlast}, 32'd0);
    chk("rst_resp_id", {24'd0, bresp, rresp, bid}, 32'd0);
    chk("rst_rid", 32'(rid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    ARESETN = 1'b1;
    @(negedge ACLK);

    // INCR write and read back with ID echo
    axi_write(4'h5, 32'h10, 8'd3, 3'd2, 2'b01, 32'hA0, 4'hF, 1'b0, -1);
    axi_read(4'h5, 32'h10, 8'd3, 3'd2, 2'b01, 1'b0);

    // Byte strobes merge into existing word
    axi_write(4'h1, 32'h40, 8'd0, 3'd2, 2'b01, 32'hFFFFFFFF, 4'hF, 1'b0, -1);
    axi_write(4'h1, 32'h40, 8'd0, 3'd2, 2'b01, 32'h12345678, 4'b0101, 1'b0, -1);
    axi_read(4'h2, 32'h40, 8'd0, 3'd2, 2'b01, 1'b0);

    // WRAP read (SLVERR x4 unless WRAP support is built)
    axi_write(4'h3, 32'h30, 8'd3, 3'd2, 2'b01, 32'hC0, 4'hF, 1'b0, -1);
    axi_read(4'h3, 32'h38, 8'd3, 3'd2, 2'b10, 1'b0);

    // Out-of-range write must not alias onto word 0
    axi_write(4'h4, 32'h0, 8'd0, 3'd2, 2'b01, 32'h11111111, 4'hF, 1'b0, -1);
    axi_write(4'h4, 32'd4096, 8'd0, 3'd2, 2'b01, 32'h5A5A5A5A, 4'hF, 1'b0, -1);
    axi_read(4'h4, 32'd4096, 8'd0, 3'd2, 2'b01, 1'b0);
    axi_read(4'h4, 32'h0, 8'd0, 3'd2, 2'b01, 1'b0);

    // wlast disagreeing with beat count: SLVERR but beats still written
    axi_write(4'h6, 32'h80, 8'd1, 3'd2, 2'b01, 32'hB0, 4'hF, 1'b1, -1);
    axi_read(4'h6, 32'h80, 8'd1, 3'd2, 2'b01, 1'b0);

    // Illegal burst type and illegal size: SLVERR, no write
    axi_write(4'h7, 32'h10, 8'd0, 3'd2, 2'b11, 32'hDEAD, 4'hF, 1'b0, -1);
    axi_read(4'h7, 32'h10, 8'd0, 3'd2, 2'b01, 1'b0);
    axi_read(4'h7, 32'h10, 8'd1, 3'd3, 2'b01, 1'b0);

    // FIXED read repeats the same word
    axi_read(4'h8, 32'h14, 8'd2, 3'd2, 2'b00, 1'b0);

    // Backpressured read concurrent with an independent write
    axi_write(4'h9, 32'h100, 8'd7, 3'd2, 2'b01, 32'hE0, 4'hF, 1'b0, -1);
    fork
      axi_read(4'h9, 32'h100, 8'd7, 3'd2, 2'b01, 1'b1);
      axi_write(4'hA, 32'h200, 8'd7, 3'd2, 2'b01, 32'hF0, 4'hF, 1'b0, -1);
    join
    axi_read(4'hA, 32'h200, 8'd7, 3'd2, 2'b01, 1'b0);

    // 256-beat INCR burst
    axi_write(4'hB, 32'h400, 8'd255, 3'd2, 2'b01, 32'h1000, 4'hF, 1'b0, -1);
    axi_read(4'hB, 32'h400, 8'd255, 3'd2, 2'b01, 1'b0);

    // Reset at beat 2 of a 4-beat write
    axi_write(4'hC, 32'h300, 8'd3, 3'd2, 2'b01, 32'hD0, 4'hF, 1'b0, 2);
    chk("abort_bvalid", 32'(bvalid), 32'd0);
    chk("abort_awready", 32'(awready), 32'd1);
    chk("abort_wready", 32'(wready), 32'd0);
    axi_read(4'hC, 32'h300, 8'd1, 3'd2, 2'b01, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
